// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the pipe_stage_buf pipeline register: occupancy codes,
// bubble fill value and lane slice helpers.
package pipe_stage_buf_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Flushed entries read back as all-zero so a bubble decodes as a NOP.
    localparam logic NOP_FILL = 1'b0;

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_entry.sv
// One holding register of the stage: valid bit, per-lane valids, PCs and payloads.
// Clear (flush) wins over load, load wins over drop.
module pipe_stage_entry
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_clear,
    input  logic                      i_load,
    input  logic                      i_drop,
    input  logic [LANES-1:0]          i_lane_vld,
    input  logic [LANES*PC_W-1:0]     i_pc,
    input  logic [LANES*DATA_W-1:0]   i_data,
    output logic                      o_vld,
    output logic [LANES-1:0]          o_lane_vld,
    output logic [LANES*PC_W-1:0]     o_pc,
    output logic [LANES*DATA_W-1:0]   o_data
);

    logic                    r_vld;
    logic [LANES-1:0]        r_lane_vld;
    logic [LANES*PC_W-1:0]   r_pc;
    logic [LANES*DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld      <= 1'b0;
            r_lane_vld <= '0;
            r_pc       <= '0;
            r_data     <= '0;
        end else if (i_clear) begin
            r_vld      <= 1'b0;
            r_lane_vld <= {LANES{NOP_FILL}};
            r_pc       <= {(LANES*PC_W){NOP_FILL}};
            r_data     <= {(LANES*DATA_W){NOP_FILL}};
        end else if (i_load) begin
            r_vld      <= 1'b1;
            r_lane_vld <= i_lane_vld;
            r_pc       <= i_pc;
            r_data     <= i_data;
        end else if (i_drop) begin
            // Payload is kept; only the valid bit falls when the beat retires.
            r_vld      <= 1'b0;
        end
    end

    assign o_vld      = r_vld;
    assign o_lane_vld = r_lane_vld;
    assign o_pc       = r_pc;
    assign o_data     = r_data;

endmodule

// File: rtl/pipe_stage_buf.sv
// Multi-lane valid/ready pipeline register between stages, with an optional
// skid entry that keeps in_ready registered, plus synchronous flush to a bubble.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 2,
    parameter int unsigned SKID   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0]          in_lane_vld,
    input  logic [LANES*PC_W-1:0]     in_pc,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES-1:0]          out_lane_vld,
    output logic [LANES*PC_W-1:0]     out_pc,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic [1:0]                occ
);

    logic                    w_accept;
    logic                    w_retire;
    logic                    w_main_vld;
    logic [LANES-1:0]        w_main_lv;
    logic [LANES*PC_W-1:0]   w_main_pc;
    logic [LANES*DATA_W-1:0] w_main_data;
    occ_e                    w_occ;

    assign w_accept = in_valid & in_ready;
    assign w_retire = out_valid & out_ready;

    assign out_valid    = w_main_vld;
    assign out_lane_vld = w_main_lv & {LANES{w_main_vld}};
    assign out_pc       = w_main_pc;
    assign out_data     = w_main_data;
    assign occ          = w_occ;

    generate
        if (SKID != 0) begin : g_skid
            logic                    w_skid_vld;
            logic [LANES-1:0]        w_skid_lv;
            logic [LANES*PC_W-1:0]   w_skid_pc;
            logic [LANES*DATA_W-1:0] w_skid_data;
            logic                    w_main_load;
            logic                    w_main_drop;
            logic                    w_skid_load;
            logic                    w_skid_drop;
            logic [LANES-1:0]        w_main_d_lv;
            logic [LANES*PC_W-1:0]   w_main_d_pc;
            logic [LANES*DATA_W-1:0] w_main_d_data;

            // A full skid entry implies a full main entry and blocks accepts,
            // so the only move at occ=2 is skid -> main on retire.
            always_comb begin
                w_main_load = 1'b0;
                w_main_drop = 1'b0;
                w_skid_load = 1'b0;
                w_skid_drop = 1'b0;
                if (w_skid_vld) begin
                    if (w_retire) begin
                        w_main_load = 1'b1;
                        w_skid_drop = 1'b1;
                    end
                end else if (w_accept && (!w_main_vld || w_retire)) begin
                    w_main_load = 1'b1;
                end else if (w_accept) begin
                    w_skid_load = 1'b1;
                end else if (w_retire) begin
                    w_main_drop = 1'b1;
                end
            end

            always_comb begin
                w_main_d_lv   = in_lane_vld;
                w_main_d_pc   = in_pc;
                w_main_d_data = in_data;
                if (w_skid_vld) begin
                    w_main_d_lv   = w_skid_lv;
                    w_main_d_pc   = w_skid_pc;
                    w_main_d_data = w_skid_data;
                end
            end

            pipe_stage_entry #(.PC_W(PC_W), .DATA_W(DATA_W), .LANES(LANES)) u_main (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_clear    (flush),
                .i_load     (w_main_load),
                .i_drop     (w_main_drop),
                .i_lane_vld (w_main_d_lv),
                .i_pc       (w_main_d_pc),
                .i_data     (w_main_d_data),
                .o_vld      (w_main_vld),
                .o_lane_vld (w_main_lv),
                .o_pc       (w_main_pc),
                .o_data     (w_main_data)
            );

            pipe_stage_entry #(.PC_W(PC_W), .DATA_W(DATA_W), .LANES(LANES)) u_skid (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_clear    (flush),
                .i_load     (w_skid_load),
                .i_drop     (w_skid_drop),
                .i_lane_vld (in_lane_vld),
                .i_pc       (in_pc),
                .i_data     (in_data),
                .o_vld      (w_skid_vld),
                .o_lane_vld (w_skid_lv),
                .o_pc       (w_skid_pc),
                .o_data     (w_skid_data)
            );

            // The skid valid flop doubles as the registered ready.
            assign in_ready = ~w_skid_vld;

            always_comb begin
                w_occ = OCC_EMPTY;
                if (w_skid_vld) begin
                    w_occ = OCC_TWO;
                end else if (w_main_vld) begin
                    w_occ = OCC_ONE;
                end
            end
        end else begin : g_single
            logic w_load;
            logic w_drop;

            assign w_load = w_accept;
            assign w_drop = w_retire & ~w_accept;

            pipe_stage_entry #(.PC_W(PC_W), .DATA_W(DATA_W), .LANES(LANES)) u_main (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_clear    (flush),
                .i_load     (w_load),
                .i_drop     (w_drop),
                .i_lane_vld (in_lane_vld),
                .i_pc       (in_pc),
                .i_data     (in_data),
                .o_vld      (w_main_vld),
                .o_lane_vld (w_main_lv),
                .o_pc       (w_main_pc),
                .o_data     (w_main_data)
            );

            assign in_ready = ~w_main_vld | out_ready;

            always_comb begin
                w_occ = OCC_EMPTY;
                if (w_main_vld) begin
                    w_occ = OCC_ONE;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a 2-lane skid instance (a) and a 1-lane
// single-entry instance (b), each checked against a FIFO scoreboard.
module tb_pipe_stage_buf;
    import pipe_stage_buf_pkg::*;

    typedef struct {
        logic [1:0]  lv;
        logic [63:0] pc;
        logic [63:0] data;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0]  a_lane_vld, a_out_lane_vld, a_occ;
    logic [63:0] a_pc, a_data, a_out_pc, a_out_data;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [0:0]  b_lane_vld, b_out_lane_vld;
    logic [1:0]  b_occ;
    logic [31:0] b_pc, b_data, b_out_pc, b_out_data;

    beat_t       q1[$];
    beat_t       q0[$];
    bit          clean1, clean0;
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned seq_a = 0;
    int unsigned seq_b = 0;

    pipe_stage_buf #(.PC_W(32), .DATA_W(32), .LANES(2), .SKID(1)) u_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (a_flush),
        .in_valid     (a_in_valid),
        .in_ready     (a_in_ready),
        .in_lane_vld  (a_lane_vld),
        .in_pc        (a_pc),
        .in_data      (a_data),
        .out_valid    (a_out_valid),
        .out_ready    (a_out_ready),
        .out_lane_vld (a_out_lane_vld),
        .out_pc       (a_out_pc),
        .out_data     (a_out_data),
        .occ          (a_occ)
    );

    pipe_stage_buf #(.PC_W(32), .DATA_W(32), .LANES(1), .SKID(0)) u_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (b_flush),
        .in_valid     (b_in_valid),
        .in_ready     (b_in_ready),
        .in_lane_vld  (b_lane_vld),
        .in_pc        (b_pc),
        .in_data      (b_data),
        .out_valid    (b_out_valid),
        .out_ready    (b_out_ready),
        .out_lane_vld (b_out_lane_vld),
        .out_pc       (b_out_pc),
        .out_data     (b_out_data),
        .occ          (b_occ)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic gen_a();
        for (int i = 0; i < 2; i++) begin
            a_pc[lane_lsb(i, 32) +: 32]   = 32'(32'h100 + 8 * seq_a + 4 * i);
            a_data[lane_lsb(i, 32) +: 32] = 32'(32'hD000_0000 + (seq_a << 4) + i);
        end
    endtask

    task automatic gen_b();
        b_pc   = 32'(32'h200 + 4 * seq_b);
        b_data = 32'(32'hC0DE_0000 + seq_b);
    endtask

    task automatic check_out1();
        chk("a.out_valid", 128'(a_out_valid), 128'(q1.size() != 0));
        chk("a.occ", 128'(a_occ), 128'(q1.size()));
        if (q1.size() != 0) begin
            chk("a.out_lane_vld", 128'(a_out_lane_vld), 128'(q1[0].lv));
            chk("a.out_pc", 128'(a_out_pc), 128'(q1[0].pc));
            chk("a.out_data", 128'(a_out_data), 128'(q1[0].data));
        end else begin
            chk("a.out_lane_vld.idle", 128'(a_out_lane_vld), 128'(0));
            if (clean1) begin
                chk("a.out_pc.bubble", 128'(a_out_pc), 128'(0));
                chk("a.out_data.bubble", 128'(a_out_data), 128'(0));
            end
        end
    endtask

    task automatic check_out0();
        chk("b.out_valid", 128'(b_out_valid), 128'(q0.size() != 0));
        chk("b.occ", 128'(b_occ), 128'(q0.size()));
        if (q0.size() != 0) begin
            chk("b.out_lane_vld", 128'(b_out_lane_vld), 128'(q0[0].lv));
            chk("b.out_pc", 128'(b_out_pc), 128'(q0[0].pc));
            chk("b.out_data", 128'(b_out_data), 128'(q0[0].data));
        end else begin
            chk("b.out_lane_vld.idle", 128'(b_out_lane_vld), 128'(0));
            if (clean0) begin
                chk("b.out_pc.bubble", 128'(b_out_pc), 128'(0));
                chk("b.out_data.bubble", 128'(b_out_data), 128'(0));
            end
        end
    endtask

    // One clock cycle: check ready before the edge, update the scoreboard with
    // this cycle's handshakes, then check outputs just after the edge.
    task automatic step();
        bit    acc1, ret1, acc0, ret0;
        beat_t bt;
        #1;
        chk("a.in_ready", 128'(a_in_ready), 128'(q1.size() != 2));
        chk("b.in_ready", 128'(b_in_ready), 128'((q0.size() == 0) || (b_out_ready == 1'b1)));
        acc1 = a_in_valid && (q1.size() != 2);
        ret1 = (q1.size() != 0) && a_out_ready;
        acc0 = b_in_valid && ((q0.size() == 0) || b_out_ready);
        ret0 = (q0.size() != 0) && b_out_ready;
        if (a_flush) begin
            q1.delete();
            clean1 = 1'b1;
        end else begin
            if (ret1) void'(q1.pop_front());
            if (acc1) begin
                bt.lv = a_lane_vld; bt.pc = a_pc; bt.data = a_data;
                q1.push_back(bt);
                clean1 = 1'b0;
            end
        end
        if (b_flush) begin
            q0.delete();
            clean0 = 1'b1;
        end else begin
            if (ret0) void'(q0.pop_front());
            if (acc0) begin
                bt.lv = 2'(b_lane_vld); bt.pc = 64'(b_pc); bt.data = 64'(b_data);
                q0.push_back(bt);
                clean0 = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_out1();
        check_out0();
        if (acc1 && !a_flush) begin seq_a++; gen_a(); end
        if (acc0 && !b_flush) begin seq_b++; gen_b(); end
    endtask

    initial begin
        rst_n = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_lane_vld = 2'b11;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_lane_vld = 1'b1;
        gen_a();
        gen_b();
        clean1 = 1'b1;
        clean0 = 1'b1;
        #1;
        check_out1();
        check_out0();
        #11;
        rst_n = 1'b1;
        #1;
        chk("a.in_ready.rel", 128'(a_in_ready), 128'(1));
        chk("b.in_ready.rel", 128'(b_in_ready), 128'(1));
        @(posedge clk);
        #1;

        // Streaming at full rate on both instances.
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        b_in_valid = 1'b1; b_out_ready = 1'b1;
        repeat (6) step();

        // Three-cycle downstream stall, then drain.
        a_out_ready = 1'b0; b_out_ready = 1'b0;
        repeat (3) step();
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        repeat (4) step();

        // Single-cycle out_ready drop.
        a_out_ready = 1'b0;
        step();
        a_out_ready = 1'b1;
        repeat (3) step();

        // Partial and empty lane masks pass through untouched.
        a_lane_vld = 2'b01; b_lane_vld = 1'b0;
        step();
        a_lane_vld = 2'b00;
        step();
        a_lane_vld = 2'b10; b_lane_vld = 1'b1;
        step();
        a_lane_vld = 2'b11;
        step();

        // Flush at occ=2 with incoming beat and downstream ready.
        a_out_ready = 1'b0;
        repeat (2) step();
        a_flush = 1'b1; a_out_ready = 1'b1;
        b_flush = 1'b1;
        step();
        a_flush = 1'b0; b_flush = 1'b0;
        seq_a++; gen_a();
        seq_b++; gen_b();
        repeat (3) step();

        // Asynchronous reset between edges while beats are held.
        a_out_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        q1.delete(); q0.delete();
        clean1 = 1'b1; clean0 = 1'b1;
        check_out1();
        check_out0();
        @(posedge clk);
        #1;
        check_out1();
        check_out0();
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        chk("a.in_ready.rst", 128'(a_in_ready), 128'(1));
        chk("b.in_ready.rst", 128'(b_in_ready), 128'(1));
        @(posedge clk);
        #1;
        check_out1();
        check_out0();

        // Recovery after reset.
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        b_in_valid = 1'b1; b_out_ready = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
